// File: rtl/coeff_modadd_stage.sv
// coeff_modadd_stage: pops coefficient beats from a valid/yumi FIFO, adds a per-polynomial scalar mod Q over two stages
// Ports:
//   clk_i, reset_n_i     clock (rising edge), asynchronous active-low reset
//   valid_i, data_i      FIFO beat available, LANES x WIDTH lanes (lane 0 in the low bits)
//   yumi_o               beat consumed this cycle
//   scalar_i             addend, sampled on beat 0 of each polynomial
//   valid_o, ready_i     output handshake
//   data_o, last_o       reduced lanes, final-beat-of-polynomial tag
//   poly_cnt_o           completed polynomials, wraps at 2^16
module coeff_modadd_stage #(
  parameter int WIDTH   = 32,
  parameter int LANES   = 4,
  parameter int N_COEFF = 16,
  parameter int Q       = 12289
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     valid_i,
  input  logic [LANES*WIDTH-1:0]   data_i,
  output logic                     yumi_o,
  input  logic [WIDTH-1:0]         scalar_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [LANES*WIDTH-1:0]   data_o,
  output logic                     last_o,
  output logic [15:0]              poly_cnt_o
);
  localparam int BEATS = N_COEFF / LANES;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [WIDTH:0] QW = (WIDTH+1)'(Q);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  logic [BW-1:0] beat_cnt;
  logic [WIDTH-1:0] scalar_q, scalar;
  logic s1_valid, s1_last, s2_free, s1_adv, s1_free, beat_last;
  logic [LANES-1:0][WIDTH:0] sum, s1_sum;
  logic [LANES*WIDTH-1:0] red;
  always_comb begin
    s2_free   = !valid_o || ready_i;
    s1_adv    = s1_valid && s2_free;
    s1_free   = !s1_valid || s1_adv;
    yumi_o    = valid_i && s1_free;
    beat_last = beat_cnt == LAST_BEAT;
    // beat 0 uses the live scalar so the latch needs no extra cycle
    scalar    = beat_cnt == '0 ? scalar_i : scalar_q;
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH:0] diff;
    assign sum[k] = {1'b0, data_i[k*WIDTH +: WIDTH]} + {1'b0, scalar};
    assign diff = s1_sum[k] - QW;
    // operands are < Q, so one conditional subtract fully reduces the sum
    assign red[k*WIDTH +: WIDTH] = s1_sum[k] >= QW ? diff[WIDTH-1:0] : s1_sum[k][WIDTH-1:0];
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      beat_cnt   <= '0;
      scalar_q   <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_sum     <= '0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      last_o     <= 1'b0;
      poly_cnt_o <= '0;
    end else begin
      if (yumi_o) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
        if (beat_cnt == '0) scalar_q <= scalar_i;
        s1_sum  <= sum;
        s1_last <= beat_last;
      end
      if (s1_free) s1_valid <= yumi_o;
      if (s2_free) valid_o <= s1_valid;
      if (s1_adv) begin
        data_o <= red;
        last_o <= s1_last;
      end
      if (valid_o && ready_i && last_o) poly_cnt_o <= poly_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_coeff_modadd_stage.sv
// tb_coeff_modadd_stage: directed vectors with hand-computed results for coeff_modadd_stage
module tb_coeff_modadd_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic valid_i = 1'b0;
  logic ready_i = 1'b1;
  logic [127:0] data_i = '0;
  logic [31:0] scalar_i = '0;
  logic yumi_o, valid_o, last_o;
  logic [127:0] data_o;
  logic [15:0] poly_cnt_o;
  int n_vec = 0;
  int n_err = 0;
  logic [127:0] din_tab [8];
  logic [127:0] exp_tab [8];
  logic [31:0] sc_tab [8];
  logic last_tab [8];

  coeff_modadd_stage #(.WIDTH(32), .LANES(4), .N_COEFF(16), .Q(12289)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(valid_i), .data_i(data_i), .yumi_o(yumi_o),
    .scalar_i(scalar_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .last_o(last_o), .poly_cnt_o(poly_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] lanes(input logic [31:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic pulse_rst();
    @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic stream(input int n);
    for (int c = 0; c < n + 2; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk("s_valid", 128'(valid_o), 128'(1));
        chk("s_data", data_o, exp_tab[c-2]);
        chk("s_last", 128'(last_o), 128'(last_tab[c-2]));
      end
      if (c < n) begin
        valid_i = 1'b1;
        data_i = din_tab[c];
        scalar_i = sc_tab[c];
        #1 chk("s_yumi", 128'(yumi_o), 128'(1));
      end else valid_i = 1'b0;
    end
    @(negedge clk);
    chk("s_idle", 128'(valid_o), 128'(0));
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", 128'(valid_o), 128'(0));
    chk("rst_data", data_o, 128'(0));
    chk("rst_last", 128'(last_o), 128'(0));
    chk("rst_poly", 128'(poly_cnt_o), 128'(0));
    chk("rst_yumi", 128'(yumi_o), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    // single beat
    @(negedge clk);
    valid_i = 1'b1; data_i = lanes(7, 6, 5, 4); scalar_i = 10;
    #1 chk("t1_yumi", 128'(yumi_o), 128'(1));
    @(negedge clk);
    valid_i = 1'b0;
    chk("t1_early", 128'(valid_o), 128'(0));
    @(negedge clk);
    chk("t1_valid", 128'(valid_o), 128'(1));
    chk("t1_data", data_o, lanes(17, 16, 15, 14));
    chk("t1_last", 128'(last_o), 128'(0));
    @(negedge clk);
    chk("t1_once", 128'(valid_o), 128'(0));
    // modular wrap, then reset while the result is on the output
    pulse_rst();
    @(negedge clk);
    valid_i = 1'b1; data_i = lanes(0, 6000, 12280, 12288); scalar_i = 9;
    #1 chk("mw_yumi", 128'(yumi_o), 128'(1));
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    chk("mw_valid", 128'(valid_o), 128'(1));
    chk("mw_data", data_o, lanes(9, 6009, 0, 8));
    #2 reset_n = 1'b0;
    #1;
    chk("mr_valid", 128'(valid_o), 128'(0));
    chk("mr_data", data_o, 128'(0));
    chk("mr_last", 128'(last_o), 128'(0));
    chk("mr_poly", 128'(poly_cnt_o), 128'(0));
    chk("mr_yumi", 128'(yumi_o), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    // backpressure across a full polynomial, scalar 1
    @(negedge clk);
    valid_i = 1'b1; data_i = lanes(3, 2, 1, 0); scalar_i = 1;
    #1 chk("bp_y0", 128'(yumi_o), 128'(1));
    @(negedge clk);
    data_i = lanes(7, 6, 5, 4);
    #1 chk("bp_y1", 128'(yumi_o), 128'(1));
    @(negedge clk);
    chk("bp_d0", data_o, lanes(4, 3, 2, 1));
    chk("bp_l0", 128'(last_o), 128'(0));
    data_i = lanes(11, 10, 9, 8);
    #1 chk("bp_y2", 128'(yumi_o), 128'(1));
    @(negedge clk);
    ready_i = 1'b0;
    data_i = lanes(15, 14, 13, 12);
    #1 chk("bp_stall", 128'(yumi_o), 128'(0));
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold_v", 128'(valid_o), 128'(1));
      chk("bp_hold_d", data_o, lanes(8, 7, 6, 5));
      chk("bp_hold_y", 128'(yumi_o), 128'(0));
    end
    @(negedge clk);
    ready_i = 1'b1;
    #1 chk("bp_resume", 128'(yumi_o), 128'(1));
    @(negedge clk);
    valid_i = 1'b0;
    chk("bp_d2", data_o, lanes(12, 11, 10, 9));
    chk("bp_l2", 128'(last_o), 128'(0));
    @(negedge clk);
    chk("bp_d3", data_o, lanes(16, 15, 14, 13));
    chk("bp_l3", 128'(last_o), 128'(1));
    chk("bp_poly0", 128'(poly_cnt_o), 128'(0));
    @(negedge clk);
    chk("bp_v_end", 128'(valid_o), 128'(0));
    chk("bp_poly1", 128'(poly_cnt_o), 128'(1));
    // scalar latch: polynomial A adds 5 despite scalar_i = 100 on beats 1-3, B adds 100
    pulse_rst();
    for (int j = 0; j < 8; j++) begin
      int add;
      add = j < 4 ? 5 : 100;
      sc_tab[j] = j == 0 ? 5 : 100;
      din_tab[j] = lanes(j*4+3, j*4+2, j*4+1, j*4);
      exp_tab[j] = lanes(j*4+3+add, j*4+2+add, j*4+1+add, j*4+add);
      last_tab[j] = j % 4 == 3;
    end
    din_tab[5] = lanes(12288, 12200, 12189, 1);
    exp_tab[5] = lanes(99, 11, 0, 101);
    stream(8);
    chk("sl_poly", 128'(poly_cnt_o), 128'(2));
    // reset mid-polynomial: the next polynomial starts again at beat 0
    pulse_rst();
    @(negedge clk);
    valid_i = 1'b1; data_i = lanes(1, 1, 1, 1); scalar_i = 50;
    #1 chk("rm_y0", 128'(yumi_o), 128'(1));
    @(negedge clk);
    data_i = lanes(2, 2, 2, 2);
    #1 chk("rm_y1", 128'(yumi_o), 128'(1));
    @(negedge clk);
    valid_i = 1'b0;
    chk("rm_v", 128'(valid_o), 128'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("rm_clr_v", 128'(valid_o), 128'(0));
    chk("rm_clr_l", 128'(last_o), 128'(0));
    chk("rm_clr_y", 128'(yumi_o), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      sc_tab[j] = 3;
      din_tab[j] = lanes(j+10, j+20, j+30, j+40);
      exp_tab[j] = lanes(j+13, j+23, j+33, j+43);
      last_tab[j] = j == 3;
    end
    chk("rm_poly0", 128'(poly_cnt_o), 128'(0));
    stream(4);
    chk("rm_poly1", 128'(poly_cnt_o), 128'(1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
